// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-requester image-ROM arbiter.
// The tag travels alongside each ROM read so the returned pixel finds its requester.
package rom_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

   localparam int ROM_LAT_DEF  = 1;
   localparam int LOCK_MAX_DEF = 64;

   function automatic logic [1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Fixed-depth delay line for {valid, id} tags, matching the ROM address-to-pixel path.
// Reset invalidates every stage so reads in flight at reset never return.
module rom_arb_tag_pipe
   import rom_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t tag_p [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_p[i] <= '0;
         end
      end else begin
         tag_p[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a shared image ROM: alternating priority on ties,
// optional bounded lock by one requester, and tagged return of the pixel to its owner.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 12,
   parameter int ROM_LAT  = ROM_LAT_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        lock,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_pixel
);

   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   arb_state_e  state, state_nxt;
   logic        owner, owner_nxt;
   logic        last_id, last_id_nxt;
   logic [7:0]  lock_cnt, lock_cnt_nxt;
   logic [1:0]  acc_vec;
   logic        acc;
   logic        acc_id;
   tag_t        tag_in;
   tag_t        tag_out;

   // Grant decode; held low while reset is asserted.
   always_comb begin
      gnt = 2'b00;
      if (rst) begin
         if (state == ARB) begin
            case (req)
               2'b01:   gnt = 2'b01;
               2'b10:   gnt = 2'b10;
               2'b11:   gnt = last_id ? 2'b01 : 2'b10;
               default: gnt = 2'b00;
            endcase
         end else begin
            gnt = req & id_onehot(owner);
         end
      end
   end

   assign acc_vec = req & gnt;
   assign acc     = |acc_vec;
   assign acc_id  = acc_vec[1];

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_id_nxt  = last_id;
      lock_cnt_nxt = lock_cnt;
      if (acc) begin
         last_id_nxt = acc_id;
      end
      case (state)
         ARB: begin
            if (acc && lock[acc_id]) begin
               state_nxt    = LOCKED;
               owner_nxt    = acc_id;
               lock_cnt_nxt = 8'd0;
            end
         end
         LOCKED: begin
            lock_cnt_nxt = lock_cnt + 8'd1;
            // Timeout wins over the owner's lock so the other drawer cannot starve.
            if (lock_cnt == CNT_LAST) begin
               state_nxt   = ARB;
               last_id_nxt = owner;
            end else if (acc && !lock[owner]) begin
               state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB;
         owner    <= 1'b0;
         last_id  <= 1'b1;
         lock_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last_id  <= last_id_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   // p0: accepted address launched to the ROM, tag enters the delay line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr <= '0;
      end else if (acc) begin
         rom_addr <= acc_id ? addr1 : addr0;
      end
   end

   assign tag_in = '{valid: acc, id: acc_id};

   rom_arb_tag_pipe #(
      .DEPTH (1 + ROM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // p1: pixel and its tag arrive together; capture and steer the valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rvalid <= 2'b00;
         rdata  <= '0;
      end else begin
         rvalid <= tag_out.valid ? id_onehot(tag_out.id) : 2'b00;
         if (tag_out.valid) begin
            rdata <= rom_pixel;
         end
      end
   end

endmodule
